// File: rtl/mac_tile_dm.sv
// mac_tile_dm: dual-mode systolic MAC tile (weight-stationary / output-stationary).
// Activations and instructions move west->east; psums, weights and drained results move
// north->south.
// Optional build macro MAC_SAT_EN: saturate WS sums and OS accumulation instead of wrapping.
module mac_tile_dm #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [bw-1:0]      in_w,
    output logic [bw-1:0]      out_e,
    input  logic [2:0]         inst_w,
    output logic [2:0]         inst_e,
    input  logic [psum_bw-1:0] in_n,
    output logic [psum_bw-1:0] out_s
);

    logic [bw-1:0]      a_q;
    logic [bw-1:0]      b_q;
    logic [bw-1:0]      w_q;
    logic [psum_bw-1:0] c_q;
    logic [psum_bw-1:0] acc_q;
    logic [2:0]         inst_q;
    logic               load_ready_q;
    logic               mode_q;

    logic [psum_bw-1:0] ws_sum;
    logic [psum_bw-1:0] os_acc_next;

    // Unsigned activation times signed weight; the product fits in psum_bw bits, so
    // truncating the psum_bw-wide multiply gives the exact signed result.
    function automatic logic [psum_bw-1:0] mult(input logic [bw-1:0] a,
                                                 input logic [bw-1:0] w);
        logic [psum_bw-1:0] ae;
        logic [psum_bw-1:0] we;
        ae = {{(psum_bw-bw){1'b0}}, a};
        we = {{(psum_bw-bw){w[bw-1]}}, w};
        return ae * we;
    endfunction

    // Signed add, one guard bit to detect overflow.
    function automatic logic [psum_bw-1:0] add(input logic [psum_bw-1:0] x,
                                                input logic [psum_bw-1:0] y);
        logic [psum_bw:0] s;
        s = {x[psum_bw-1], x} + {y[psum_bw-1], y};
`ifdef MAC_SAT_EN
        if (s[psum_bw] != s[psum_bw-1]) begin
            return s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
        end
`endif
        return s[psum_bw-1:0];
    endfunction

    // Arithmetic for both modes: WS from registers, OS from the live inputs.
    always_comb begin
        ws_sum      = add(mult(a_q, b_q), c_q);
        os_acc_next = add(acc_q, mult(in_w, in_n[bw-1:0]));
    end

    // Tile state update; a mode change only clears the accumulator and re-arms loading.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            w_q          <= '0;
            c_q          <= '0;
            acc_q        <= '0;
            inst_q       <= '0;
            load_ready_q <= 1'b1;
            mode_q       <= 1'b0;
        end else begin
            mode_q      <= mode;
            inst_q[2:1] <= inst_w[2:1];
            if (mode != mode_q) begin
                acc_q        <= '0;
                load_ready_q <= 1'b1;
                inst_q[0]    <= 1'b0;
            end else begin
                if (inst_w[0] | inst_w[1]) begin
                    a_q <= in_w;
                end
                if (!mode_q) begin
                    // The capturing load is swallowed so each tile keeps the first weight.
                    inst_q[0] <= inst_w[0] & ~load_ready_q;
                    c_q       <= in_n;
                    if (inst_w[2]) begin
                        load_ready_q <= 1'b1;
                    end else if (inst_w[0] && load_ready_q) begin
                        b_q          <= in_w;
                        load_ready_q <= 1'b0;
                    end
                end else begin
                    inst_q[0] <= inst_w[0];
                    if (inst_w[1]) begin
                        w_q <= in_n[bw-1:0];
                    end
                    // Drain shifts the column unsaturated and takes precedence over execute.
                    if (inst_w[2]) begin
                        acc_q <= in_n;
                    end else if (inst_w[1]) begin
                        acc_q <= os_acc_next;
                    end
                end
            end
        end
    end

    // Outputs: in OS the south port shows the accumulator only while draining.
    always_comb begin
        out_e  = a_q;
        inst_e = inst_q;
        out_s  = ws_sum;
        if (mode_q) begin
            if (inst_w[2]) begin
                out_s = acc_q;
            end else begin
                out_s = {{(psum_bw-bw){w_q[bw-1]}}, w_q};
            end
        end
    end

endmodule

// File: tb/tb_mac_tile_dm.sv
// Directed self-checking bench for mac_tile_dm (bw=4, psum_bw=16).
module tb_mac_tile_dm;

    logic        clk;
    logic        reset;
    logic        mode;
    logic [3:0]  in_w;
    logic [3:0]  out_e;
    logic [2:0]  inst_w;
    logic [2:0]  inst_e;
    logic [15:0] in_n;
    logic [15:0] out_s;

    int n_checks = 0;
    int n_errors = 0;

    mac_tile_dm #(
        .bw      (4),
        .psum_bw (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .mode   (mode),
        .in_w   (in_w),
        .out_e  (out_e),
        .inst_w (inst_w),
        .inst_e (inst_e),
        .in_n   (in_n),
        .out_s  (out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs settle 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] inst, input logic [3:0] a, input logic [15:0] n);
        inst_w = inst;
        in_w   = a;
        in_n   = n;
    endtask

    initial begin
        reset = 1'b1;
        mode  = 1'b0;
        drive(3'b000, 4'h0, 16'h0);
        step();
        step();
        reset = 1'b0;
        check("rst_out_e", 32'(out_e), 32'h0);
        check("rst_inst_e", 32'(inst_e), 32'h0);
        check("rst_out_s", 32'(out_s), 32'h0);
        check("rst_load_ready", 32'(dut.load_ready_q), 32'h1);

        // WS load: first weight is kept, second load is forwarded east
        drive(3'b001, 4'hD, 16'h0);
        step();
        check("ws_load1_inst_e0", 32'(inst_e[0]), 32'h0);
        check("ws_load1_b", 32'(dut.b_q), 32'hD);
        drive(3'b001, 4'h2, 16'h0);
        step();
        check("ws_load2_inst_e0", 32'(inst_e[0]), 32'h1);
        check("ws_load2_out_e", 32'(out_e), 32'h2);
        check("ws_load2_b", 32'(dut.b_q), 32'hD);
        check("ws_load2_out_s", 32'(out_s), 32'hFFFA); // 2 * -3

        // WS execute: 5 * -3 + 100
        drive(3'b010, 4'h5, 16'd100);
        step();
        check("ws_exec_out_s", 32'(out_s), 32'd85);
        check("ws_exec_inst_e", 32'(inst_e), 32'h2);

        // Re-arm then reload
        drive(3'b100, 4'h0, 16'h0);
        step();
        check("rearm_inst_e", 32'(inst_e), 32'h4);
        check("rearm_load_ready", 32'(dut.load_ready_q), 32'h1);
        drive(3'b001, 4'h7, 16'h0);
        step();
        check("reload_b", 32'(dut.b_q), 32'h7);
        check("reload_inst_e", 32'(inst_e), 32'h0);

        // Re-arm and load together: re-arm wins, no capture
        drive(3'b100, 4'h0, 16'h0);
        step();
        drive(3'b101, 4'h3, 16'h0);
        step();
        check("collide_b", 32'(dut.b_q), 32'h7);
        check("collide_load_ready", 32'(dut.load_ready_q), 32'h1);
        check("collide_inst_e", 32'(inst_e), 32'h4);

        // Overflow: 15 * 7 + 0x7FFF
        drive(3'b010, 4'hF, 16'h7FFF);
        step();
`ifdef MAC_SAT_EN
        check("ws_overflow", 32'(out_s), 32'h7FFF);
`else
        check("ws_overflow", 32'(out_s), 32'h8068);
`endif

        // Switch to OS
        drive(3'b000, 4'h0, 16'h0);
        mode = 1'b1;
        step();
        check("os_switch_acc", 32'(dut.acc_q), 32'h0);
        step();

        // OS execute: 3*2 + 4*-1 + 5*7 = 37
        drive(3'b010, 4'd3, 16'd2);
        step();
        check("os_exec1_acc", 32'(dut.acc_q), 32'd6);
        check("os_exec1_out_s", 32'(out_s), 32'd2);
        drive(3'b010, 4'd4, 16'hFFFF);
        step();
        check("os_exec2_out_s", 32'(out_s), 32'hFFFF);
        drive(3'b010, 4'd5, 16'd7);
        step();
        check("os_exec3_acc", 32'(dut.acc_q), 32'd37);
        check("os_exec3_out_e", 32'(out_e), 32'd5);

        // Drain with top-of-column 0
        drive(3'b100, 4'h0, 16'h0);
        #1;
        check("os_drain_out_s", 32'(out_s), 32'd37);
        step();
        check("os_drain_acc", 32'(dut.acc_q), 32'h0);
        check("os_drain_inst_e", 32'(inst_e), 32'h4);
        drive(3'b000, 4'h0, 16'h0);
        #1;
        check("os_idle_out_s", 32'(out_s), 32'd7);

        // Drain + execute: drain wins, a and w still captured
        drive(3'b010, 4'd3, 16'd2);
        step();
        drive(3'b110, 4'd5, 16'd9);
        step();
        check("os_dx_acc", 32'(dut.acc_q), 32'd9);
        check("os_dx_out_e", 32'(out_e), 32'd5);
        drive(3'b000, 4'h0, 16'h0);
        #1;
        check("os_dx_out_s", 32'(out_s), 32'hFFF9);

        // Rebuild 37 then reset mid-operation
        drive(3'b100, 4'h0, 16'h0);
        step();
        drive(3'b010, 4'd3, 16'd2);
        step();
        drive(3'b010, 4'd4, 16'hFFFF);
        step();
        drive(3'b010, 4'd5, 16'd7);
        step();
        check("os_rebuild_acc", 32'(dut.acc_q), 32'd37);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(3'b000, 4'h0, 16'h0);
        #1;
        check("midrst_out_s", 32'(out_s), 32'h0);
        check("midrst_inst_e", 32'(inst_e), 32'h0);
        check("midrst_load_ready", 32'(dut.load_ready_q), 32'h1);
        check("midrst_acc", 32'(dut.acc_q), 32'h0);
        check("midrst_out_e", 32'(out_e), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_tile_dm.md
Name: mac_tile_dm

Overview:
Dual-mode processing element for the systolic MAC array. It is the parametrised successor of the single-mode weight-stationary tile.
- Weight-stationary (WS): weight held locally, partial sums flow north→south.
- Output-stationary (OS): weights flow north→south, the sum accumulates locally, and the result drains down the column as a shift chain.
- Adds a kernel re-arm instruction and optional saturating arithmetic. One tile per array cell; activations and instructions travel west→east.

Parameters:
bw, 4, activation/weight width (activation unsigned, weight two's-complement signed)
psum_bw, 16, partial-sum/accumulator width (signed)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
mode  input  1  0=WS, 1=OS; static while inst_w != 0
in_w  input  bw  activation (WS: also weight during load)
out_e  output  bw  registered activation to east
inst_w  input  3  [0] kernel load, [1] execute, [2] WS: re-arm load / OS: drain
inst_e  output  3  registered instruction to east
in_n  input  psum_bw  WS: psum in; OS execute: weight in [bw-1:0]; OS drain: accumulator chain in
out_s  output  psum_bw  WS: psum out; OS: weight out / drained accumulator

Behaviour:
Common rules
- All state updates on posedge clk. Reset is synchronous, active-high, and has priority over everything.
- Reset values: a_q=0, b_q=0, w_q=0, c_q=0, acc_q=0, inst_q=0, load_ready_q=1, mode_q=0. Hence out_e=0, inst_e=0, out_s=0.
- mode_q <= mode. If mode != mode_q: acc_q <= 0, load_ready_q <= 1, and no other datapath update that cycle.
- prod = zero-extended a × sign-extended weight, sign-extended to psum_bw. Sums wrap modulo 2^psum_bw.
- out_e = a_q; inst_e = inst_q; inst_q[2:1] <= inst_w[2:1].
- a_q <= in_w when inst_w[0] | inst_w[1].

WS (mode_q=0)
- Load: if inst_w[0] & load_ready_q, then b_q <= in_w and load_ready_q <= 0.
- inst_q[0] <= inst_w[0] only when load_ready_q=0 (old value). The capturing cycle is therefore not forwarded east, so each tile keeps the first weight it sees.
- inst_w[2] (re-arm): load_ready_q <= 1. Forwarded east next cycle. If inst_w[2] and inst_w[0] are asserted in the same cycle, re-arm wins and no weight is captured.
- c_q <= in_n every cycle.
- out_s = a_q*b_q + c_q, combinational from registers. Latency from in_w/in_n to out_s is one edge.

OS (mode_q=1)
- inst_q[0] <= inst_w[0] (pass-through; load ignored).
- Execute (inst_w[1], no drain): w_q <= in_n[bw-1:0] and acc_q <= acc_q + in_w*in_n[bw-1:0]. Uses the unregistered inputs, so there is no accumulation lag.
- Drain (inst_w[2]): acc_q <= in_n. Column behaves as a shift register; the top tile is fed 0, which clears the chain.
- Simultaneous drain + execute: drain wins and the product is dropped. a_q and w_q still capture.
- out_s = acc_q when inst_w[2]=1; otherwise sign-extended w_q.

Optional Feature:
MAC_SAT_EN
- Defined: every WS out_s sum and OS accumulate saturates to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
- Undefined: modulo wrap.
- Drain moves are never saturated.

Test Plan:
- WS load (bw=4, psum_bw=16): reset; inst_w=001 in_w=4'hD; then inst_w=001 in_w=4'h2 → b_q=-3. inst_e[0]=0 after the first edge, 1 after the second; out_e=2.
- WS execute: inst_w=010 in_w=5 in_n=100 → out_s=85 after one edge; inst_e=010.
- Re-arm: inst_w=100, then inst_w=001 in_w=7 → b_q=7; inst_e[2]=1 one cycle after the re-arm.
- OS: mode=1 for two cycles; execute (a,w)=(3,2),(4,-1),(5,7) → acc_q=37. Drain with in_n=0 → out_s=37 that cycle, acc_q=0 after.
- Overflow: WS in_n=16'h7FFF, a=15, b=7 → out_s=16'h8068 without MAC_SAT_EN, 16'h7FFF with it.
- Reset mid-operation: OS acc_q=37, reset asserted one cycle → out_s=0, inst_e=0, load_ready_q=1, acc_q=0.
